multi_signal_drawer: RTL and testbench
======================================

MULTI_SIGNAL_DRAWER -- requirements
Module: multi_signal_drawer

Interface
REQ-001 SHALL have parameter N_CH, default 2, number of overlaid waveform channels (1..4).
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 12, signed sample width per channel.
REQ-003 SHALL have parameters ACTIVE_HOR 1280, ACTIVE_VERT 1024, X_W 11, Y_W 11, ADD_SIZE 11: active raster and counter/address widths.
REQ-004 SHALL have parameter ZERO_LEVEL, default ACTIVE_VERT/2, screen row of sample value 0.
REQ-005 SHALL have parameter PIXEL_THICKNESS, default 1, extra rows drawn above and below the trace (0 = single row).
REQ-006 SHALL have ports CLK104MHZ in 1 pixel clock; RST_N in 1 asynchronous active-low reset.
REQ-007 SHALL have ports current_x_read in X_W; current_y_read in Y_W; sVert, sHor, blnk in 1 each: raster position and sync from VGA configuration.
REQ-008 SHALL have ports ADC_OUT in N_CH*SAMPLE_WIDTH, channel k at bits [k*SAMPLE_WIDTH +: SAMPLE_WIDTH]; gain_shift in 3, arithmetic right shift of samples; ch_enable in N_CH, per-channel draw enable.
REQ-009 SHALL have ports pixel out 12 RGB colour; signalReadX out X_W; signalReadY out Y_W; signalsVert, signalsHor, signalblnk out 1 each: delayed raster/sync.
REQ-010 SHALL have ports ADD out ADD_SIZE, buffer read address; activeBRAMselect out 1, ping-pong buffer select; frame_done out 1, one-cycle pulse.

Function
REQ-011 ADD SHALL register current_x_read when x < ACTIVE_HOR, else hold; ADC_OUT SHALL be sampled 2 cycles after x is presented (1-cycle buffer read latency).
REQ-012 Per channel: loc = ZERO_LEVEL - (sample >>> gain_shift), computed in signed Y_W+2 bits, clamped to [0, ACTIVE_VERT-1].
REQ-013 Per channel, prev_loc SHALL hold loc of the preceding column; at x == 0, prev_loc SHALL equal the current loc (no fill across lines).
REQ-014 Channel k SHALL hit when ch_enable[k] and lo-PIXEL_THICKNESS <= y <= hi+PIXEL_THICKNESS, lo/hi = min/max(loc, prev_loc), compared signed without underflow.
REQ-015 pixel SHALL be the colour of the lowest-index hitting channel, 12'h000 if none hit or delayed blnk is 1.
REQ-016 pixel and all signal* outputs SHALL have exactly 3-cycle latency from current_x_read/current_y_read and stay mutually aligned.
REQ-017 At x == ACTIVE_HOR-1 and y == ACTIVE_VERT-1, activeBRAMselect SHALL toggle and frame_done pulse for one cycle, once per frame, even if the position is held multiple cycles.
REQ-018 x, y outside the active region SHALL not update ADD or prev_loc and SHALL yield pixel 0.

Reset
REQ-019 RST_N low SHALL immediately clear pixel, ADD, signal*, activeBRAMselect, frame_done and all pipeline stages to 0, and set prev_loc to ZERO_LEVEL.
REQ-020 Reset deasserted mid-frame SHALL resume drawing from the next presented position; the first 3 output cycles SHALL be 0.

Configuration
REQ-021 With SIGNAL_DRAWER_LINE_FILL_EN defined, lo/hi SHALL span loc and prev_loc (vertical interpolation between columns).
REQ-022 Without SIGNAL_DRAWER_LINE_FILL_EN, lo = hi = loc; prev_loc registers SHALL be omitted.

Structure
REQ-023 Package signal_drawer_pkg SHALL hold the per-channel colour table (ch0 12'h6F0, ch1 12'hF60, ch2 12'h0CF, ch3 12'hFF0) and shared width constants.
REQ-024 Sub-module trace_hit_unit SHALL implement REQ-012 to REQ-014 for one channel, instantiated N_CH times.

Verification
REQ-025 Ch0 sample 0, gain_shift 0, y = 512 at x = 10 -> pixel 12'h6F0 3 cycles later; y = 514 -> 12'h000.
REQ-026 Ch0 samples +100 at x = 20, -100 at x = 21, FILL_EN defined -> column 21 lit for rows 411..613; undefined -> only 611..613.
REQ-027 Ch0 and ch1 both sample 0, both enabled -> 12'h6F0; ch_enable = 2'b10 -> 12'hF60.
REQ-028 Sample +2047, gain_shift 0 -> loc clamped to 0, rows 0..1 lit; gain_shift 2 -> loc 1, rows 0..2 lit.
REQ-029 Raster at (1279, 1023) held 3 cycles -> activeBRAMselect toggles once, frame_done high exactly 1 cycle.
REQ-030 RST_N pulsed low mid-line -> all outputs 0 asynchronously; drawing resumes correctly after 3 cycles.

Source files
------------

// File: rtl/signal_drawer_pkg.sv
// Shared constants and per-channel trace colours for the multi-channel waveform drawer.
package signal_drawer_pkg;

   localparam int RGB_W       = 12;
   localparam int MAX_CH      = 4;
   localparam int GAIN_W      = 3;
   localparam int PIPE_STAGES = 3;

   typedef logic [RGB_W-1:0] rgb_t;

   localparam rgb_t PIXEL_OFF = 12'h000;

   function automatic rgb_t ch_colour(input int ch);
      case (ch)
         0:       return 12'h6F0;
         1:       return 12'hF60;
         2:       return 12'h0CF;
         default: return 12'hFF0;
      endcase
   endfunction

endpackage

// File: rtl/trace_hit_unit.sv
// One channel: sample -> screen row, then row hit test against the current raster line.
// SIGNAL_DRAWER_LINE_FILL_EN spans the hit range between this column and the previous one.
module trace_hit_unit
   import signal_drawer_pkg::*;
#(
   parameter int SAMPLE_WIDTH    = 12,
   parameter int Y_W             = 11,
   parameter int ACTIVE_VERT     = 1024,
   parameter int ZERO_LEVEL      = ACTIVE_VERT / 2,
   parameter int PIXEL_THICKNESS = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic signed [SAMPLE_WIDTH-1:0] sample,
   input  logic [GAIN_W-1:0]              gain_shift,
   input  logic                           en,
   input  logic [Y_W-1:0]                 y,
   input  logic                           col_act,
   input  logic                           line_start,
   output logic                           hit
);

   localparam int LW = Y_W + 2;
   localparam logic signed [LW-1:0] ZL    = LW'(ZERO_LEVEL);
   localparam logic signed [LW-1:0] VMAX  = LW'(ACTIVE_VERT - 1);
   localparam logic signed [LW-1:0] THICK = LW'(PIXEL_THICKNESS);

   logic signed [SAMPLE_WIDTH-1:0] scaled;
   logic signed [LW-1:0]           scaled_ext, loc_raw, lo_s, hi_s, y_s;
   logic [Y_W-1:0]                 loc, lo, hi;

   always_comb begin
      scaled     = sample >>> gain_shift;
      scaled_ext = LW'(scaled);
      loc_raw    = ZL - scaled_ext;
      if (loc_raw[LW-1])
         loc = '0;
      else if (loc_raw > VMAX)
         loc = VMAX[Y_W-1:0];
      else
         loc = loc_raw[Y_W-1:0];
   end

`ifdef SIGNAL_DRAWER_LINE_FILL_EN
   logic [Y_W-1:0] prev_loc_q, prev_loc_d, prev_eff;

   // First column of a line has no left neighbour, so it draws as a point.
   always_comb begin
      prev_eff   = line_start ? loc : prev_loc_q;
      prev_loc_d = col_act ? loc : prev_loc_q;
      lo         = (loc < prev_eff) ? loc : prev_eff;
      hi         = (loc < prev_eff) ? prev_eff : loc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         prev_loc_q <= Y_W'(ZERO_LEVEL);
      else
         prev_loc_q <= prev_loc_d;
   end
`else
   logic unused_fill;
   assign unused_fill = ^{clk, rst_n, col_act, line_start};

   always_comb begin
      lo = loc;
      hi = loc;
   end
`endif

   // Widen before subtracting the thickness so row 0 cannot wrap.
   always_comb begin
      y_s  = $signed({2'b00, y});
      lo_s = $signed({2'b00, lo}) - THICK;
      hi_s = $signed({2'b00, hi}) + THICK;
      hit  = en && (y_s >= lo_s) && (y_s <= hi_s);
   end

endmodule

// File: rtl/multi_signal_drawer.sv
// Overlays N_CH sampled waveforms on a VGA raster with a fixed 3-cycle pixel pipeline.
// Define SIGNAL_DRAWER_LINE_FILL_EN to join adjacent columns with vertical segments.
module multi_signal_drawer
   import signal_drawer_pkg::*;
#(
   parameter int N_CH            = 2,
   parameter int SAMPLE_WIDTH    = 12,
   parameter int ACTIVE_HOR      = 1280,
   parameter int ACTIVE_VERT     = 1024,
   parameter int X_W             = 11,
   parameter int Y_W             = 11,
   parameter int ADD_SIZE        = 11,
   parameter int ZERO_LEVEL      = ACTIVE_VERT / 2,
   parameter int PIXEL_THICKNESS = 1
) (
   input  logic                         CLK104MHZ,
   input  logic                         RST_N,
   input  logic [X_W-1:0]               current_x_read,
   input  logic [Y_W-1:0]               current_y_read,
   input  logic                         sVert,
   input  logic                         sHor,
   input  logic                         blnk,
   input  logic [N_CH*SAMPLE_WIDTH-1:0] ADC_OUT,
   input  logic [GAIN_W-1:0]            gain_shift,
   input  logic [N_CH-1:0]              ch_enable,
   output logic [RGB_W-1:0]             pixel,
   output logic [X_W-1:0]               signalReadX,
   output logic [Y_W-1:0]               signalReadY,
   output logic                         signalsVert,
   output logic                         signalsHor,
   output logic                         signalblnk,
   output logic [ADD_SIZE-1:0]          ADD,
   output logic                         activeBRAMselect,
   output logic                         frame_done
);

   localparam logic [X_W-1:0] X_LAST = X_W'(ACTIVE_HOR - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(ACTIVE_VERT - 1);

   typedef struct packed {
      logic [X_W-1:0] x;
      logic [Y_W-1:0] y;
      logic           svert;
      logic           shor;
      logic           blnk;
      logic           act;
      logic           frame_end;
   } rast_t;

   rast_t [PIPE_STAGES-1:0] pipe_q, pipe_d;
   logic [ADD_SIZE-1:0]     add_q, add_d;
   logic                    last_seen_q, last_seen_d;
   logic                    bram_sel_q, bram_sel_d;
   rgb_t                    pixel_q, pixel_d;
   logic                    in_active, at_last;

   logic [N_CH-1:0] hit, first_hit;
   rgb_t            rgb_acc [N_CH:0];

   // Frame end is edge-detected so a held last position counts once.
   always_comb begin
      in_active   = (current_x_read <= X_LAST) && (current_y_read <= Y_LAST);
      at_last     = (current_x_read == X_LAST) && (current_y_read == Y_LAST);
      last_seen_d = at_last;

      pipe_d[0].x         = current_x_read;
      pipe_d[0].y         = current_y_read;
      pipe_d[0].svert     = sVert;
      pipe_d[0].shor      = sHor;
      pipe_d[0].blnk      = blnk;
      pipe_d[0].act       = in_active;
      pipe_d[0].frame_end = at_last && !last_seen_q;
      pipe_d[1]           = pipe_q[0];
      pipe_d[2]           = pipe_q[1];

      add_d      = in_active ? ADD_SIZE'(current_x_read) : add_q;
      bram_sel_d = bram_sel_q ^ pipe_q[1].frame_end;
   end

   // Stage 2 meets the buffer data; lowest channel index wins the pixel.
   assign rgb_acc[0] = PIXEL_OFF;

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      trace_hit_unit #(
         .SAMPLE_WIDTH    (SAMPLE_WIDTH),
         .Y_W             (Y_W),
         .ACTIVE_VERT     (ACTIVE_VERT),
         .ZERO_LEVEL      (ZERO_LEVEL),
         .PIXEL_THICKNESS (PIXEL_THICKNESS)
      ) u_hit (
         .clk        (CLK104MHZ),
         .rst_n      (RST_N),
         .sample     (ADC_OUT[k*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
         .gain_shift (gain_shift),
         .en         (ch_enable[k]),
         .y          (pipe_q[1].y),
         .col_act    (pipe_q[1].act),
         .line_start (pipe_q[1].x == '0),
         .hit        (hit[k])
      );

      if (k == 0) begin : g_first
         assign first_hit[k] = hit[k];
      end else begin : g_rest
         assign first_hit[k] = hit[k] && !(|hit[k-1:0]);
      end

      assign rgb_acc[k+1] = rgb_acc[k] | (first_hit[k] ? ch_colour(k) : PIXEL_OFF);
   end

   always_comb begin
      pixel_d = PIXEL_OFF;
      if (pipe_q[1].act && !pipe_q[1].blnk)
         pixel_d = rgb_acc[N_CH];
   end

   always_ff @(posedge CLK104MHZ or negedge RST_N) begin
      if (!RST_N) begin
         pipe_q      <= '0;
         add_q       <= '0;
         last_seen_q <= 1'b0;
         bram_sel_q  <= 1'b0;
         pixel_q     <= PIXEL_OFF;
      end else begin
         pipe_q      <= pipe_d;
         add_q       <= add_d;
         last_seen_q <= last_seen_d;
         bram_sel_q  <= bram_sel_d;
         pixel_q     <= pixel_d;
      end
   end

   logic unused_stage;
   assign unused_stage = pipe_q[2].act;

   assign pixel            = pixel_q;
   assign signalReadX      = pipe_q[2].x;
   assign signalReadY      = pipe_q[2].y;
   assign signalsVert      = pipe_q[2].svert;
   assign signalsHor       = pipe_q[2].shor;
   assign signalblnk       = pipe_q[2].blnk;
   assign ADD              = add_q;
   assign activeBRAMselect = bram_sel_q;
   assign frame_done       = pipe_q[2].frame_end;

endmodule

// File: tb/tb_multi_signal_drawer.sv
// Directed bench for multi_signal_drawer; a behavioural 1-cycle buffer feeds ADC_OUT from ADD.
module tb_multi_signal_drawer;

   localparam int          SW     = 12;
   localparam logic [10:0] IDLE_X = 11'd1300;

`ifdef SIGNAL_DRAWER_LINE_FILL_EN
   localparam bit FILL = 1'b1;
`else
   localparam bit FILL = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [10:0]   cx, cy;
   logic          cv, chs, cb;
   logic [2*SW-1:0] adc_q;
   logic [2:0]    gain;
   logic [1:0]    ch_en;
   logic [11:0]   pixel;
   logic [10:0]   rx, ry, add;
   logic          rv, rh, rb, sel, fdone;

   logic signed [SW-1:0] mem0 [0:2047];
   logic signed [SW-1:0] mem1 [0:2047];

   int n_assert = 0;
   int n_fail   = 0;
   int fd_cnt;

   always #5 clk = ~clk;

   always @(posedge clk) adc_q <= {mem1[add], mem0[add]};

   multi_signal_drawer dut (
      .CLK104MHZ        (clk),
      .RST_N            (rst_n),
      .current_x_read   (cx),
      .current_y_read   (cy),
      .sVert            (cv),
      .sHor             (chs),
      .blnk             (cb),
      .ADC_OUT          (adc_q),
      .gain_shift       (gain),
      .ch_enable        (ch_en),
      .pixel            (pixel),
      .signalReadX      (rx),
      .signalReadY      (ry),
      .signalsVert      (rv),
      .signalsHor       (rh),
      .signalblnk       (rb),
      .ADD              (add),
      .activeBRAMselect (sel),
      .frame_done       (fdone)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pres(input logic [10:0] x, input logic [10:0] y, input logic v, input logic h);
      @(negedge clk);
      cx  = x;
      cy  = y;
      cv  = v;
      chs = h;
   endtask

   // Previous column, target column, two idle slots; returns when the target is at the outputs.
   task automatic probe(input logic [10:0] xp, input logic [10:0] x, input logic [10:0] y);
      pres(xp, y, 1'b0, 1'b0);
      pres(x, y, 1'b1, 1'b0);
      pres(IDLE_X, y, 1'b0, 1'b1);
      pres(IDLE_X, y, 1'b0, 1'b1);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 2048; i++) begin
         mem0[i] = '0;
         mem1[i] = '0;
      end
      mem0[20]   = 12'sd100;
      mem0[21]   = -12'sd100;
      mem0[1279] = 12'sd100;
      mem0[0]    = -12'sd100;
      mem0[30]   = 12'sd2047;
      mem0[31]   = 12'sd2047;

      rst_n = 1'b0; cx = IDLE_X; cy = '0; cv = 1'b0; chs = 1'b0; cb = 1'b0;
      gain = 3'd0; ch_en = 2'b01;
      #2;
      chk("reset_pixel", pixel, 12'h000);
      chk("reset_add", add, 11'd0);
      chk("reset_sel", sel, 1'b0);
      chk("reset_frame_done", fdone, 1'b0);
      chk("reset_readx", rx, 11'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Zero sample sits on row 512, thickness 1 -> rows 511..513
      probe(11'd9, 11'd10, 11'd512);
      chk("zero_y512", pixel, 12'h6F0);
      chk("align_x", rx, 11'd10);
      chk("align_y", ry, 11'd512);
      chk("align_vert", rv, 1'b1);
      chk("align_hor", rh, 1'b0);
      chk("add_hold", add, 11'd10);
      probe(11'd9, 11'd10, 11'd514);
      chk("zero_y514", pixel, 12'h000);
      probe(11'd9, 11'd10, 11'd511);
      chk("zero_y511", pixel, 12'h6F0);

      cb = 1'b1;
      probe(11'd9, 11'd10, 11'd512);
      chk("blank_pixel", pixel, 12'h000);
      chk("blank_out", rb, 1'b1);
      cb = 1'b0;

      // +100 then -100: loc 412 -> 612
      probe(11'd20, 11'd21, 11'd410);
      chk("fill_y410", pixel, 12'h000);
      probe(11'd20, 11'd21, 11'd411);
      chk("fill_y411", pixel, FILL ? 12'h6F0 : 12'h000);
      probe(11'd20, 11'd21, 11'd500);
      chk("fill_y500", pixel, FILL ? 12'h6F0 : 12'h000);
      probe(11'd20, 11'd21, 11'd611);
      chk("fill_y611", pixel, 12'h6F0);
      probe(11'd20, 11'd21, 11'd613);
      chk("fill_y613", pixel, 12'h6F0);
      probe(11'd20, 11'd21, 11'd614);
      chk("fill_y614", pixel, 12'h000);

      // Line start never joins to the end of the previous line
      probe(11'd1279, 11'd0, 11'd500);
      chk("linestart_y500", pixel, 12'h000);
      probe(11'd1279, 11'd0, 11'd612);
      chk("linestart_y612", pixel, 12'h6F0);

      // Clamp at the top of the screen
      probe(11'd30, 11'd31, 11'd1);
      chk("clamp_g0_y1", pixel, 12'h6F0);
      probe(11'd30, 11'd31, 11'd2);
      chk("clamp_g0_y2", pixel, 12'h000);
      gain = 3'd2;
      probe(11'd30, 11'd31, 11'd2);
      chk("clamp_g2_y2", pixel, 12'h6F0);
      probe(11'd30, 11'd31, 11'd3);
      chk("clamp_g2_y3", pixel, 12'h000);
      gain = 3'd0;

      ch_en = 2'b11;
      probe(11'd39, 11'd40, 11'd512);
      chk("prio_both", pixel, 12'h6F0);
      ch_en = 2'b10;
      probe(11'd39, 11'd40, 11'd512);
      chk("prio_ch1", pixel, 12'hF60);
      ch_en = 2'b00;
      probe(11'd39, 11'd40, 11'd512);
      chk("prio_none", pixel, 12'h000);
      ch_en = 2'b01;

      // Last position held for three cycles
      chk("frame_sel_before", sel, 1'b0);
      fd_cnt = 0;
      @(negedge clk);
      cx = 11'd1279; cy = 11'd1023;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 2) begin
            cx = IDLE_X; cy = '0;
         end
         fd_cnt += int'(fdone);
      end
      chk("frame_done_count", fd_cnt, 1);
      chk("frame_sel_after", sel, 1'b1);

      // Asynchronous reset with a lit pixel at the outputs
      probe(11'd9, 11'd10, 11'd512);
      chk("prereset_pixel", pixel, 12'h6F0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_pixel", pixel, 12'h000);
      chk("async_readx", rx, 11'd0);
      chk("async_ready", ry, 11'd0);
      chk("async_vert", rv, 1'b0);
      chk("async_add", add, 11'd0);
      chk("async_sel", sel, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      cx = 11'd10; cy = 11'd512; cv = 1'b0; chs = 1'b0;
      @(negedge clk);
      chk("resume_c1_pixel", pixel, 12'h000);
      chk("resume_c1_ready", ry, 11'd0);
      @(negedge clk);
      chk("resume_c2_pixel", pixel, 12'h000);
      @(negedge clk);
      chk("resume_c3_pixel", pixel, 12'h6F0);
      chk("resume_c3_ready", ry, 11'd512);
      cx = IDLE_X;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
